// File: rtl/pipe_stage_buffer.sv
// Generic pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// The main register always drives the output; the skid register catches the beat that
// arrives while the output is backpressured, so ready never depends combinationally on
// downstream ready.
module pipe_stage_buffer #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       occupancy
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             acc_in;
    logic             acc_out;

    // Handshake outputs derive only from state (and reset), never from outReady.
    always_comb begin
        inReady   = reset & (state_q != StTwo);
        outValid  = (state_q != StEmpty);
        outData   = main_q;
        occupancy = state_q;
        acc_in    = inValid & inReady;
        acc_out   = outValid & outReady & ~stall;
    end

    // Next-state and data-register update; flush empties the stage but keeps data.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc_in) begin
                        state_d = StOne;
                        main_d  = inData;
                    end
                end
                StOne: begin
                    if (acc_in && acc_out) begin
                        main_d = inData;
                    end else if (acc_in) begin
                        state_d = StTwo;
                        skid_d  = inData;
                    end else if (acc_out) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // inReady is low here, so only the drain path exists.
                    if (acc_out) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StEmpty;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer: a 32-bit default instance and an
// 8-bit instance with RESET_VAL=8'hFF share the same controls.
module tb_pipe_stage_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        stall;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_data32;
    logic [1:0]  occ32;

    logic [7:0]  in_data8;
    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  out_data8;
    logic [1:0]  occ8;

    int total;
    int bad;

    assign in_data8 = in_data[7:0];

    pipe_stage_buffer dut32 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .inValid   (in_valid),
        .inReady   (in_ready32),
        .inData    (in_data),
        .outValid  (out_valid32),
        .outReady  (out_ready),
        .outData   (out_data32),
        .occupancy (occ32)
    );

    pipe_stage_buffer #(
        .WIDTH     (8),
        .RESET_VAL (8'hFF)
    ) dut8 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .inValid   (in_valid),
        .inReady   (in_ready8),
        .inData    (in_data8),
        .outValid  (out_valid8),
        .outReady  (out_ready),
        .outData   (out_data8),
        .occupancy (occ8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (in_ready32 !== 1'b0) begin
                bad++;
                $display("FAIL reset_inready cyc%0d: got %b want 0", i, in_ready32);
            end
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready32 !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_inready: got %b want 1", in_ready32);
        end
        total++;
        if (out_valid32 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outvalid: got %b want 0", out_valid32);
        end
        total++;
        if (occ32 !== 2'd0) begin
            bad++;
            $display("FAIL reset_occ: got %0d want 0", occ32);
        end
        total++;
        if (out_data32 !== 32'h0) begin
            bad++;
            $display("FAIL reset_outdata: got %h want 00000000", out_data32);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        stall     = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            step();
            total++;
            if (out_data32 !== 32'(i) || out_valid32 !== 1'b1) begin
                bad++;
                $display("FAIL stream_data%0d: got %h/%b want %h/1", i, out_data32,
                         out_valid32, i);
            end
            total++;
            if (occ32 !== 2'd1 || in_ready32 !== 1'b1) begin
                bad++;
                $display("FAIL stream_occ%0d: got occ=%0d rdy=%b want occ=1 rdy=1", i,
                         occ32, in_ready32);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid32 !== 1'b0 || occ32 !== 2'd0) begin
            bad++;
            $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", out_valid32, occ32);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_valid = 1'b0;
        total++;
        if (occ32 !== 2'd2 || in_ready32 !== 1'b0 || out_data32 !== 32'hA) begin
            bad++;
            $display("FAIL bp_full: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a", occ32,
                     in_ready32, out_data32);
        end
        step();
        total++;
        if (out_data32 !== 32'hA || out_valid32 !== 1'b1 || occ32 !== 2'd2) begin
            bad++;
            $display("FAIL bp_hold: got d=%h v=%b occ=%0d want d=a v=1 occ=2", out_data32,
                     out_valid32, occ32);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_data32 !== 32'hB || occ32 !== 2'd1 || in_ready32 !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain1: got d=%h occ=%0d rdy=%b want d=b occ=1 rdy=1",
                     out_data32, occ32, in_ready32);
        end
        step();
        total++;
        if (out_valid32 !== 1'b0 || occ32 !== 2'd0) begin
            bad++;
            $display("FAIL bp_drain2: got v=%b occ=%0d want v=0 occ=0", out_valid32, occ32);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                in_data  = 32'h66;
            end else begin
                in_valid = 1'b0;
            end
            step();
            total++;
            if (out_data32 !== 32'h55 || out_valid32 !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold%0d: got d=%h v=%b want d=55 v=1", i, out_data32,
                         out_valid32);
            end
        end
        in_valid = 1'b0;
        total++;
        if (occ32 !== 2'd2 || in_ready32 !== 1'b0) begin
            bad++;
            $display("FAIL stall_full: got occ=%0d rdy=%b want occ=2 rdy=0", occ32, in_ready32);
        end
        stall = 1'b0;
        step();
        total++;
        if (out_data32 !== 32'h66 || occ32 !== 2'd1) begin
            bad++;
            $display("FAIL stall_release: got d=%h occ=%0d want d=66 occ=1", out_data32, occ32);
        end
        step();
        total++;
        if (out_valid32 !== 1'b0) begin
            bad++;
            $display("FAIL stall_empty: got v=%b want 0", out_valid32);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        flush   = 1'b1;
        in_data = 32'h77;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid32 !== 1'b0 || occ32 !== 2'd0 || in_ready32 !== 1'b1) begin
            bad++;
            $display("FAIL flush_state: got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1",
                     out_valid32, occ32, in_ready32);
        end
        // Data registers survive a flush; the dropped 0x77 must not land in main.
        total++;
        if (out_data32 !== 32'h11) begin
            bad++;
            $display("FAIL flush_data: got %h want 00000011", out_data32);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid32 !== 1'b0 || out_data32 === 32'h77) begin
                bad++;
                $display("FAIL flush_after%0d: got v=%b d=%h want v=0, d!=77", i,
                         out_valid32, out_data32);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_param();
        // Reset mid-transfer: a held beat is discarded and both widths reload RESET_VAL.
        in_valid = 1'b1;
        in_data  = 32'h99;
        step();
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        reset = 1'b1;
        #1;
        total++;
        if (out_valid32 !== 1'b0 || out_data32 !== 32'h0) begin
            bad++;
            $display("FAIL midreset32: got v=%b d=%h want v=0 d=0", out_valid32, out_data32);
        end
        total++;
        if (out_valid8 !== 1'b0 || out_data8 !== 8'hFF || occ8 !== 2'd0) begin
            bad++;
            $display("FAIL reset8: got v=%b d=%h occ=%0d want v=0 d=ff occ=0", out_valid8,
                     out_data8, occ8);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            step();
            total++;
            if (out_data8 !== 8'(i) || occ8 !== 2'd1 || in_ready8 !== 1'b1) begin
                bad++;
                $display("FAIL stream8_%0d: got d=%h occ=%0d rdy=%b want d=%h occ=1 rdy=1", i,
                         out_data8, occ8, in_ready8, i);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised successor to the single-register PC pipeline latch.
- Generic pipeline-stage register between any two stages (fetch→decode, decode→execute, …) with parametrised payload width and reset value.
- Adds valid/ready handshake, a 2-entry skid buffer so backpressure never drops a beat, stall and flush controls, and an occupancy output.

Parameters:
- WIDTH, 32: payload width in bits.
- RESET_VAL, 32'h0 (WIDTH bits): value loaded into both data registers on reset.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-low (0 = reset).
- flush  input  1  synchronous pipeline flush; drops all held beats.
- stall  input  1  holds the output side; equivalent to outReady=0.
- inValid  input  1  upstream beat valid.
- inReady  output  1  stage can accept a beat this cycle.
- inData  input  WIDTH  upstream payload.
- outValid  output  1  outData holds a valid beat.
- outReady  input  1  downstream accepts this cycle.
- outData  output  WIDTH  payload to downstream.
- occupancy  output  2  beats held: 0, 1 or 2.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low.
- Storage:
  - main register drives outData.
  - skid register is used only when occupancy=2.
- State encoding: EMPTY (occ 0), ONE (occ 1), TWO (occ 2); occupancy is the encoded state.
- Definitions:
  - accIn = inValid & inReady.
  - accOut = outValid & outReady & ~stall.
- Combinational outputs:
  - inReady = reset & (state != TWO). It is 0 while reset is low and depends only on state, never on outReady (no combinational ready path).
  - outValid = (state != EMPTY).
- Transitions (reset=1, flush=0):
  - EMPTY: accIn → ONE, main<=inData. Otherwise stay.
  - ONE, accIn & accOut → ONE, main<=inData.
  - ONE, accIn only → TWO, skid<=inData, main unchanged.
  - ONE, accOut only → EMPTY.
  - ONE, neither → hold.
  - TWO: accOut → ONE, main<=skid. Otherwise hold. inReady=0, so accIn is impossible.
- Latency: a beat accepted at edge N appears on outData with outValid=1 in the cycle after edge N (1 cycle), if the stage was empty or draining.
- Ordering: strict FIFO; the skid beat is always delivered after the main beat.
- Stability: while outValid=1 and not accOut, outData and outValid hold exactly.
- Stall: accOut is blocked; the input side still fills up to TWO, then inReady drops.
- Reset (reset=0 at an edge): state<=EMPTY, main<=RESET_VAL, skid<=RESET_VAL.
  - After reset: outValid=0, occupancy=0, outData=RESET_VAL.
  - inReady=1 in the first cycle after reset releases.
  - Reset mid-transfer discards all beats.
- Flush (reset=1, flush=1 at an edge): state<=EMPTY; data registers keep their values.
  - An inValid beat presented in a flush cycle is dropped, even if inReady=1.
  - An outReady handshake in a flush cycle still counts as consumed by downstream.
  - flush has priority over stall and all handshakes; reset has priority over flush.
- No arithmetic; occupancy never exceeds 2 and never underflows.

Test Plan:
- Reset: hold reset=0 for 3 cycles with inValid=1, inData=0xDEADBEEF; release → outValid=0, occupancy=0, outData=0x00000000, inReady=0 during reset, inReady=1 in the first cycle after release.
- Streaming: outReady=1, stall=0, inValid=1 with inData=1,2,3,4 on consecutive cycles → outData=1,2,3,4 each one cycle later, occupancy stays 1, inReady stays 1.
- Backpressure: load 0xA then 0xB with outReady=0 → occupancy=2, inReady=0, outData=0xA held. Raise outReady → 0xA, then 0xB delivered; inReady returns to 1 after the first drain, no beat lost or duplicated.
- Stall: occupancy=1 with outData=0x55, outReady=1, stall=1 for 4 cycles → outData stays 0x55 and outValid stays 1; a second beat 0x66 fills skid (occupancy=2). Drop stall → 0x55 then 0x66.
- Flush: occupancy=2 with inValid=1, inData=0x77 in the flush cycle → next cycle outValid=0, occupancy=0, inReady=1; 0x77 never appears on outData.
- Parameter: WIDTH=8, RESET_VAL=8'hFF → after reset outData=8'hFF; the streaming test passes with 8-bit data 0x01..0x04.
